// File: rtl/fslcd_pwrseq_pkg.sv
// Shared state codes and per-state output decode for the LCD power sequencer.
// Imported by the sequencer, the status register decode and the testbench.
package fslcd_pwrseq_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_OFF       = 3'd0,
    ST_PWR_WAIT  = 3'd1,
    ST_SYNC      = 3'd2,
    ST_DATA_WAIT = 3'd3,
    ST_ON        = 3'd4,
    ST_BL_OFF    = 3'd5,
    ST_DATA_OFF  = 3'd6,
    ST_OFF_HOLD  = 3'd7
  } state_t;

  function automatic logic st_timed(state_t s);
    return (s == ST_PWR_WAIT) || (s == ST_DATA_WAIT) || (s == ST_BL_OFF) ||
           (s == ST_DATA_OFF) || (s == ST_OFF_HOLD);
  endfunction

  function automatic logic st_pwr(state_t s);
    return (s != ST_OFF) && (s != ST_OFF_HOLD);
  endfunction

  function automatic logic st_data(state_t s);
    return (s == ST_DATA_WAIT) || (s == ST_ON) || (s == ST_BL_OFF);
  endfunction

  function automatic logic st_bl(state_t s);
    return (s == ST_ON);
  endfunction

endpackage

// File: rtl/fslcd_dly_cnt.sv
// Loadable down-counter with terminal-count flag; holds at zero, never wraps.
// Also used by the backlight PWM block.
module fslcd_dly_cnt #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             load,
  input  logic             dec,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fslcd_pwrseq.sv
// LCD panel power sequencer: panel supply -> data drive -> backlight on enable,
// reverse order on disable, with data start aligned to a vsync leading edge.
//
// state      | meaning
// OFF        | everything off, waiting for en
// PWR_WAIT   | supply on, settling before vsync search
// SYNC       | supply on, waiting for vsync leading edge
// DATA_WAIT  | data driven, waiting before backlight
// ON         | fully on, ready=1
// BL_OFF     | backlight off, data still driven
// DATA_OFF   | data off, supply still on
// OFF_HOLD   | supply off, minimum off time before re-power
module fslcd_pwrseq
  import fslcd_pwrseq_pkg::*;
#(
  parameter int unsigned CNT_W      = 24,
  parameter int unsigned T_PWR2DATA = 1000,
  parameter int unsigned T_DATA2BL  = 2000,
  parameter int unsigned T_BL2DATA  = 2000,
  parameter int unsigned T_DATA2PWR = 1000,
  parameter int unsigned T_OFF_MIN  = 5000,
  parameter bit          VS_POL     = 1'b1
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       en,
  input  logic       vsync,
  input  logic       vid_active,
  output logic       lcd_pwr,
  output logic       data_on,
  output logic       de_out,
  output logic       bl_en,
  output logic       ready,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] LD_PWR2DATA = CNT_W'(T_PWR2DATA - 1);
  localparam logic [CNT_W-1:0] LD_DATA2BL  = CNT_W'(T_DATA2BL - 1);
  localparam logic [CNT_W-1:0] LD_BL2DATA  = CNT_W'(T_BL2DATA - 1);
  localparam logic [CNT_W-1:0] LD_DATA2PWR = CNT_W'(T_DATA2PWR - 1);
  localparam logic [CNT_W-1:0] LD_OFF_MIN  = CNT_W'(T_OFF_MIN - 1);

  state_t           state_q;
  state_t           state_d;
  logic             vs_q;
  logic             vs_edge;
  logic             cnt_load;
  logic             cnt_dec;
  logic [CNT_W-1:0] cnt_val;
  logic             cnt_zero;

  assign vs_edge = (vsync == VS_POL) && (vs_q != VS_POL);

  fslcd_dly_cnt #(.CNT_W(CNT_W)) u_dly_cnt (
    .clk    (clk),
    .resetn (resetn),
    .load   (cnt_load),
    .dec    (cnt_dec),
    .value  (cnt_val),
    .zero   (cnt_zero)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_OFF;
      vs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= vsync;
    end
  end

  // en=0 aborts power-up into the matching point of the power-down path.
  always_comb begin
    state_d  = state_q;
    cnt_val  = '0;
    case (state_q)
      ST_OFF:       if (en) state_d = ST_PWR_WAIT;
      ST_PWR_WAIT:  if (!en) state_d = ST_OFF_HOLD;
                    else if (cnt_zero) state_d = ST_SYNC;
      ST_SYNC:      if (!en) state_d = ST_OFF_HOLD;
                    else if (vs_edge) state_d = ST_DATA_WAIT;
      ST_DATA_WAIT: if (!en) state_d = ST_DATA_OFF;
                    else if (cnt_zero) state_d = ST_ON;
      ST_ON:        if (!en) state_d = ST_BL_OFF;
      ST_BL_OFF:    if (cnt_zero) state_d = ST_DATA_OFF;
      ST_DATA_OFF:  if (cnt_zero) state_d = ST_OFF_HOLD;
      ST_OFF_HOLD:  if (cnt_zero) state_d = ST_OFF;
      default:      state_d = ST_OFF;
    endcase

    case (state_d)
      ST_PWR_WAIT:  cnt_val = LD_PWR2DATA;
      ST_DATA_WAIT: cnt_val = LD_DATA2BL;
      ST_BL_OFF:    cnt_val = LD_BL2DATA;
      ST_DATA_OFF:  cnt_val = LD_DATA2PWR;
      ST_OFF_HOLD:  cnt_val = LD_OFF_MIN;
      default:      cnt_val = '0;
    endcase
  end

  assign cnt_load = (state_d != state_q);
  assign cnt_dec  = st_timed(state_q);

  // Output flops load the decode of the next state so they track state_q exactly.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lcd_pwr <= 1'b0;
      data_on <= 1'b0;
      bl_en   <= 1'b0;
      ready   <= 1'b0;
      de_out  <= 1'b0;
    end else begin
      lcd_pwr <= st_pwr(state_d);
      data_on <= st_data(state_d);
      bl_en   <= st_bl(state_d);
      ready   <= (state_d == ST_ON);
      de_out  <= vid_active & data_on;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_fslcd_pwrseq.sv
// Scoreboard bench for fslcd_pwrseq: two instances (active-high and active-low
// vsync) checked each cycle against a phase/duration reference model.
module tb_fslcd_pwrseq;
  import fslcd_pwrseq_pkg::*;

  localparam int T_PWR2DATA = 8;
  localparam int T_DATA2BL  = 6;
  localparam int T_BL2DATA  = 5;
  localparam int T_DATA2PWR = 4;
  localparam int T_OFF_MIN  = 10;
  localparam int VS_PERIOD  = 40;

  typedef struct packed {
    logic       pwr;
    logic       data;
    logic       bl;
    logic       de;
    logic       rdy;
    logic [2:0] st;
  } obs_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic en = 1'b0;
  logic vs_hi = 1'b0;
  logic vs_lo;
  logic vid_active = 1'b0;
  logic vs_run = 1'b0;
  int   vs_cnt = 0;

  logic pwr_a, data_a, de_a, bl_a, rdy_a;
  logic pwr_b, data_b, de_b, bl_b, rdy_b;
  logic [2:0] st_a, st_b;
  obs_t obs_a, obs_b;

  assign vs_lo = ~vs_hi;
  assign obs_a = {pwr_a, data_a, bl_a, de_a, rdy_a, st_a};
  assign obs_b = {pwr_b, data_b, bl_b, de_b, rdy_b, st_b};

  always #5 clk = ~clk;

  fslcd_pwrseq #(.CNT_W(24), .T_PWR2DATA(T_PWR2DATA), .T_DATA2BL(T_DATA2BL),
    .T_BL2DATA(T_BL2DATA), .T_DATA2PWR(T_DATA2PWR), .T_OFF_MIN(T_OFF_MIN),
    .VS_POL(1'b1)) dut_hi (
    .clk(clk), .resetn(resetn), .en(en), .vsync(vs_hi), .vid_active(vid_active),
    .lcd_pwr(pwr_a), .data_on(data_a), .de_out(de_a), .bl_en(bl_a),
    .ready(rdy_a), .state(st_a));

  fslcd_pwrseq #(.CNT_W(24), .T_PWR2DATA(T_PWR2DATA), .T_DATA2BL(T_DATA2BL),
    .T_BL2DATA(T_BL2DATA), .T_DATA2PWR(T_DATA2PWR), .T_OFF_MIN(T_OFF_MIN),
    .VS_POL(1'b0)) dut_lo (
    .clk(clk), .resetn(resetn), .en(en), .vsync(vs_lo), .vid_active(vid_active),
    .lcd_pwr(pwr_b), .data_on(data_b), .de_out(de_b), .bl_en(bl_b),
    .ready(rdy_b), .state(st_b));

  int tests = 0;
  int fails = 0;
  obs_t exp_q[$];

  // Reference model: phase index, cycles spent in phase, phase duration table.
  int   dur [8] = '{0, T_PWR2DATA, 0, T_DATA2BL, 0, T_BL2DATA, T_DATA2PWR, T_OFF_MIN};
  int   m_phase = 0;
  int   m_age = 0;
  logic m_vs_prev = 1'b0;
  logic m_data = 1'b0;

  function automatic obs_t look(int ph, logic de);
    obs_t o;
    o.pwr  = (ph >= 1) && (ph <= 6);
    o.data = (ph >= 3) && (ph <= 5);
    o.bl   = (ph == 4);
    o.rdy  = (ph == 4);
    o.de   = de;
    o.st   = 3'(ph);
    return o;
  endfunction

  always @(negedge resetn) exp_q.delete();

  always @(posedge clk) begin
    int   nxt;
    logic fin;
    logic vedge;
    obs_t o;
    if (!resetn) begin
      m_phase   <= 0;
      m_age     <= 0;
      m_vs_prev <= 1'b0;
      m_data    <= 1'b0;
      exp_q.push_back('0);
    end else begin
      vedge = vs_hi && !m_vs_prev;
      fin   = (dur[m_phase] > 0) && (m_age + 1 >= dur[m_phase]);
      nxt   = m_phase;
      case (m_phase)
        0: if (en) nxt = 1;
        1: nxt = !en ? 7 : (fin ? 2 : 1);
        2: nxt = !en ? 7 : (vedge ? 3 : 2);
        3: nxt = !en ? 6 : (fin ? 4 : 3);
        4: if (!en) nxt = 5;
        5: if (fin) nxt = 6;
        6: if (fin) nxt = 7;
        default: if (fin) nxt = 0;
      endcase
      o = look(nxt, vid_active & m_data);
      m_age     <= (nxt != m_phase) ? 0 : m_age + 1;
      m_phase   <= nxt;
      m_vs_prev <= vs_hi;
      m_data    <= o.data;
      exp_q.push_back(o);
    end
  end

  task automatic check(string name, obs_t act, obs_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s t=%0t got pwr,data,bl,de,rdy=%b%b%b%b%b st=%0d want %b%b%b%b%b st=%0d",
               name, $time, act.pwr, act.data, act.bl, act.de, act.rdy, act.st,
               exp.pwr, exp.data, exp.bl, exp.de, exp.rdy, exp.st);
    end
  endtask

  always @(negedge clk) begin
    obs_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("vs_pol1", obs_a, e);
      check("vs_pol0", obs_b, e);
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (vs_run) begin
        vs_cnt = (vs_cnt + 1) % VS_PERIOD;
        vs_hi  = (vs_cnt < 3);
      end else begin
        vs_hi = 1'b0;
      end
      vid_active = 1'($urandom_range(0, 1));
    end
  end

  task automatic step(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_state(int ph, int limit, string name);
    int k = 0;
    while (int'(st_a) != ph && k < limit) begin
      step(1);
      k++;
    end
    tests++;
    if (int'(st_a) != ph) begin
      fails++;
      $display("FAIL %s timeout got state=%0d want %0d", name, st_a, ph);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout t=%0t", $time);
    $fatal(1, "bench timeout");
  end

  initial begin
    step(3);
    resetn = 1'b1;
    vs_run = 1'b1;
    step(2);

    en = 1'b1;
    wait_state(4, 200, "powerup_on");
    step(5);

    en = 1'b0;
    wait_state(0, 60, "powerdown_off");
    step(3);

    vs_run = 1'b0;
    en = 1'b1;
    wait_state(2, 40, "reach_sync");
    step(5);
    en = 1'b0;
    wait_state(0, 40, "sync_abort_off");
    vs_run = 1'b1;
    step(2);

    en = 1'b1;
    wait_state(4, 200, "second_on");
    en = 1'b0;
    wait_state(7, 40, "reach_hold");
    step(2);
    en = 1'b1;
    wait_state(1, 40, "reenable_pwr");
    wait_state(4, 200, "reenable_on");
    step(3);

    @(posedge clk);
    #3;
    resetn = 1'b0;
    #1;
    check("async_rst_hi", obs_a, '0);
    check("async_rst_lo", obs_b, '0);
    step(2);
    resetn = 1'b1;
    wait_state(4, 200, "post_reset_on");

    for (int i = 0; i < 30; i++) begin
      en     = 1'($urandom_range(0, 1));
      vs_run = ($urandom_range(0, 7) != 0);
      step($urandom_range(1, 60));
    end

    vs_run = 1'b1;
    en = 1'b0;
    step(40);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
